// File: rtl/n64_joybus_pkg.sv
// Shared joybus constants: command codes, identity bytes, bit timing in microseconds
// and the device FSM state encoding.
`timescale 1ns/1ps
package n64_joybus_pkg;
  localparam logic [7:0] CMD_INFO   = 8'h00;
  localparam logic [7:0] CMD_STATUS = 8'h01;
  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] ID_HI      = 8'h05;
  localparam logic [7:0] ID_LO      = 8'h00;

  localparam int T_BIT    = 4;
  localparam int T_SHORT  = 1;
  localparam int T_LONG   = 3;
  localparam int T_DSTOP  = 2;
  localparam int T_SAMPLE = 2;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_RX_LOW    = 3'd1;
  localparam logic [2:0] ST_RX_HIGH   = 3'd2;
  localparam logic [2:0] ST_TURN      = 3'd3;
  localparam logic [2:0] ST_TX_BIT    = 3'd4;
  localparam logic [2:0] ST_TX_STOP   = 3'd5;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd6;

  // Commands that produce a reply frame; every other well-formed command is silent.
  function automatic logic resp_cmd(input logic [7:0] c);
    return (c == CMD_INFO) || (c == CMD_STATUS) || (c == CMD_RESET);
  endfunction
endpackage

// File: rtl/n64_joybus_device_line_sync.sv
// Two-flop synchronizer for the joy line with registered fall/rise pulses that are
// aligned with the delivered level.
`timescale 1ns/1ps
module joybus_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic line_i,
  output logic level_o,
  output logic fall_o,
  output logic rise_o
);
  logic [2:0] sync_q;
  logic       fall_q;
  logic       rise_q;

  // Idle line is high, so reset to 1 to avoid a spurious falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 3'b111;
      fall_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], line_i};
      fall_q <= sync_q[2] & ~sync_q[1];
      rise_q <= ~sync_q[2] & sync_q[1];
    end
  end

  assign level_o = sync_q[2];
  assign fall_o  = fall_q;
  assign rise_o  = rise_q;
endmodule

// File: rtl/n64_joybus_device.sv
// Controller side of the N64 joybus: decodes host command frames and answers the
// info (00/FF) and button status (01) commands on an open-drain line.
`timescale 1ns/1ps
module n64_joybus_device
  import n64_joybus_pkg::*;
#(
  parameter int         US_TICKS    = 50,
  parameter int         IDLE_US     = 4,
  parameter int         LONG_LOW_US = 8,
  parameter int         TURN_US     = 2,
  parameter logic [7:0] PAK_STATUS  = 8'h02
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        joy_i,
  output logic        joy_oe,
  input  logic [15:0] buttons,
  input  logic [7:0]  stick_x,
  input  logic [7:0]  stick_y,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        busy,
  output logic        rx_error
);
  localparam int CW = $clog2(LONG_LOW_US * US_TICKS + 1);
  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] SAMPLE_T   = CW'(T_SAMPLE * US_TICKS);
  localparam logic [CW-1:0] LONG_T     = CW'(LONG_LOW_US * US_TICKS);
  localparam logic [CW-1:0] IDLE_END   = CW'(IDLE_US * US_TICKS - 1);
  localparam logic [CW-1:0] TURN_END   = CW'(TURN_US * US_TICKS - 1);
  localparam logic [CW-1:0] BIT_END    = CW'(T_BIT * US_TICKS - 1);
  localparam logic [CW-1:0] SHORT_T    = CW'(T_SHORT * US_TICKS);
  localparam logic [CW-1:0] LONG_BIT_T = CW'(T_LONG * US_TICKS);
  localparam logic [CW-1:0] DSTOP_T    = CW'(T_DSTOP * US_TICKS);
  localparam logic [CW-1:0] STOP_END   = CW'((T_DSTOP + T_SHORT) * US_TICKS - 1);

  logic             level_s, fall_s, rise_s;
  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [15:0]      shift_q, shift_d;
  logic [4:0]       bitcnt_q, bitcnt_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [1:0]       last_idx_q, last_idx_d;
  logic [3:0][7:0]  resp_q, resp_d;
  logic [7:0]       cmd_byte_q, cmd_byte_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             rx_error_q, rx_error_d;
  logic             joy_oe_q, joy_oe_d;
  logic             busy_q;
  logic             rx_bit_s, frame_ok_s, cur_bit_s;

  joybus_line_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .line_i  (joy_i),
    .level_o (level_s),
    .fall_o  (fall_s),
    .rise_o  (rise_s)
  );

  // A rise before the sample point means the line read high at 2us, i.e. a 1.
  assign rx_bit_s   = (cnt_q < SAMPLE_T) ? 1'b1 : 1'b0;
  assign frame_ok_s = (bitcnt_q == 5'd9) && shift_q[0] && (shift_q[15:9] == 7'd0);
  assign cur_bit_s  = resp_q[byte_idx_q][bit_idx_q];

  // Next-state logic for the receive / turnaround / transmit sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    bitcnt_d    = bitcnt_q;
    byte_idx_d  = byte_idx_q;
    bit_idx_d   = bit_idx_q;
    last_idx_d  = last_idx_q;
    resp_d      = resp_q;
    cmd_byte_d  = cmd_byte_q;
    cmd_valid_d = 1'b0;
    rx_error_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = CNT_ZERO;
        if (fall_s) begin
          state_d  = ST_RX_LOW;
          shift_d  = 16'h0000;
          bitcnt_d = 5'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RX_LOW: begin
        if (cnt_q == LONG_T) begin
          state_d    = ST_WAIT_HIGH;
          cnt_d      = CNT_ZERO;
          rx_error_d = 1'b1;
        end else if (rise_s) begin
          state_d  = ST_RX_HIGH;
          cnt_d    = CNT_ZERO;
          shift_d  = {shift_q[14:0], rx_bit_s};
          bitcnt_d = (bitcnt_q == 5'd31) ? bitcnt_q : bitcnt_q + 5'd1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RX_HIGH: begin
        if (fall_s) begin
          state_d = ST_RX_LOW;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == IDLE_END) begin
          cnt_d = CNT_ZERO;
          if (frame_ok_s) begin
            cmd_byte_d  = shift_q[8:1];
            cmd_valid_d = 1'b1;
            if (shift_q[8:1] == CMD_STATUS) begin
              resp_d     = {stick_y, stick_x, buttons[7:0], buttons[15:8]};
              last_idx_d = 2'd3;
            end else begin
              resp_d     = {8'h00, PAK_STATUS, ID_LO, ID_HI};
              last_idx_d = 2'd2;
            end
            state_d = resp_cmd(shift_q[8:1]) ? ST_TURN : ST_IDLE;
          end else begin
            rx_error_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_TURN: begin
        if (cnt_q == TURN_END) begin
          state_d    = ST_TX_BIT;
          cnt_d      = CNT_ZERO;
          byte_idx_d = 2'd0;
          bit_idx_d  = 3'd7;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_TX_BIT: begin
        if (cnt_q == BIT_END) begin
          cnt_d = CNT_ZERO;
          if (bit_idx_q != 3'd0) begin
            bit_idx_d = bit_idx_q - 3'd1;
          end else if (byte_idx_q == last_idx_q) begin
            state_d = ST_TX_STOP;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            bit_idx_d  = 3'd7;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_TX_STOP: begin
        if (cnt_q == STOP_END) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_WAIT_HIGH: begin
        if (!level_s) begin
          cnt_d = CNT_ZERO;
        end else if (cnt_q == IDLE_END) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Line drive follows the current bit phase; registering it keeps every low time exact.
  always_comb begin
    case (state_q)
      ST_TX_BIT:  joy_oe_d = cur_bit_s ? (cnt_q < SHORT_T) : (cnt_q < LONG_BIT_T);
      ST_TX_STOP: joy_oe_d = (cnt_q < DSTOP_T);
      default:    joy_oe_d = 1'b0;
    endcase
  end

  // State and output registers; reset releases the line without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= CNT_ZERO;
      shift_q     <= 16'h0000;
      bitcnt_q    <= 5'd0;
      byte_idx_q  <= 2'd0;
      bit_idx_q   <= 3'd7;
      last_idx_q  <= 2'd2;
      resp_q      <= {4{8'h00}};
      cmd_byte_q  <= 8'h00;
      cmd_valid_q <= 1'b0;
      rx_error_q  <= 1'b0;
      joy_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      bitcnt_q    <= bitcnt_d;
      byte_idx_q  <= byte_idx_d;
      bit_idx_q   <= bit_idx_d;
      last_idx_q  <= last_idx_d;
      resp_q      <= resp_d;
      cmd_byte_q  <= cmd_byte_d;
      cmd_valid_q <= cmd_valid_d;
      rx_error_q  <= rx_error_d;
      joy_oe_q    <= joy_oe_d;
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign joy_oe    = joy_oe_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_byte  = cmd_byte_q;
  assign busy      = busy_q;
  assign rx_error  = rx_error_q;
endmodule

// File: tb/tb_n64_joybus_device.sv
// Bench for n64_joybus_device: a host BFM drives joy line frames and a line monitor
// decodes the device reply, compared against a command-table reference model.
`timescale 1ns/1ps
module tb_n64_joybus_device;
  localparam int US = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        host_low = 1'b0;
  logic        joy_oe;
  logic [15:0] buttons = 16'h0000;
  logic [7:0]  stick_x = 8'h00;
  logic [7:0]  stick_y = 8'h00;
  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  logic        busy;
  logic        rx_error;
  wire         joy_line = ~(host_low | joy_oe);

  n64_joybus_device #(.US_TICKS(US)) dut (
    .clk       (clk),
    .reset     (reset),
    .joy_i     (joy_line),
    .joy_oe    (joy_oe),
    .buttons   (buttons),
    .stick_x   (stick_x),
    .stick_y   (stick_y),
    .cmd_valid (cmd_valid),
    .cmd_byte  (cmd_byte),
    .busy      (busy),
    .rx_error  (rx_error)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  logic rx_bits [$];
  int   low_len = 0;
  int   stop_seen = 0;
  int   oe_cycles = 0;
  int   cv_count = 0;
  int   err_count = 0;

  // Line monitor: classifies each device low pulse by its length (1us=1, 3us=0, 2us=stop).
  always @(negedge clk) begin
    if (joy_oe === 1'b1) begin
      low_len = low_len + 1;
      oe_cycles = oe_cycles + 1;
    end else if (low_len > 0) begin
      if (low_len < 6) rx_bits.push_back(1'b1);
      else if (low_len < 10) stop_seen = stop_seen + 1;
      else rx_bits.push_back(1'b0);
      low_len = 0;
    end
    if (cmd_valid === 1'b1) cv_count = cv_count + 1;
    if (rx_error === 1'b1) err_count = err_count + 1;
  end

  function automatic int model_len(input logic [7:0] c);
    if (c == 8'h00 || c == 8'hFF) return 3;
    else if (c == 8'h01) return 4;
    else return 0;
  endfunction

  function automatic logic [7:0] model_byte(input logic [7:0] c, input int i,
                                            input logic [15:0] b, input logic [7:0] x,
                                            input logic [7:0] y);
    logic [7:0] info [3];
    logic [7:0] stat [4];
    info = '{8'h05, 8'h00, 8'h02};
    stat = '{b[15:8], b[7:0], x, y};
    if (c == 8'h01) return stat[i];
    else return info[i];
  endfunction

  function automatic logic [7:0] got_byte(input int i);
    logic [7:0] v = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (8 * i + k < rx_bits.size()) v = {v[6:0], rx_bits[8 * i + k]};
      else v = {v[6:0], 1'bx};
    end
    return v;
  endfunction

  task automatic clear_mon();
    rx_bits.delete();
    low_len = 0;
    stop_seen = 0;
    oe_cycles = 0;
    cv_count = 0;
    err_count = 0;
  endtask

  task automatic send_bit(input logic b);
    host_low = 1'b1;
    repeat (b ? US : 3 * US) @(negedge clk);
    host_low = 1'b0;
    repeat (b ? 3 * US : US) @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] data, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(data[i]);
    send_bit(1'b1);
  endtask

  task automatic wait_cv(input string name);
    int t = 0;
    while (cv_count == 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (cv_count == 0) begin
      errors++;
      $display("FAIL %s cmd_valid_timeout got none want pulse", name);
    end
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (busy !== 1'b0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_timeout busy=%b want 0", name, busy);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({joy_oe, cmd_valid, busy, rx_error} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got oe/cv/busy/err=%b want 0000", {joy_oe, cmd_valid, busy, rx_error});
    end
    checks++;
    if (cmd_byte !== 8'h00) begin
      errors++;
      $display("FAIL reset_cmd_byte got %h want 00", cmd_byte);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({joy_oe, busy} !== 2'b00) begin
      errors++;
      $display("FAIL post_reset got oe/busy=%b want 00", {joy_oe, busy});
    end
  endtask

  task automatic test_info(input logic [7:0] c);
    clear_mon();
    send_frame({8'h00, c}, 8);
    wait_idle("info");
    checks++;
    if (cv_count !== 1 || cmd_byte !== c) begin
      errors++;
      $display("FAIL info_cmd got cv=%0d byte=%h want 1 %h", cv_count, cmd_byte, c);
    end
    checks++;
    if (rx_bits.size() !== 8 * model_len(c) || stop_seen !== 1) begin
      errors++;
      $display("FAIL info_len got bits=%0d stops=%0d want %0d 1", rx_bits.size(), stop_seen, 8 * model_len(c));
    end
    for (int i = 0; i < model_len(c); i++) begin
      checks++;
      if (got_byte(i) !== model_byte(c, i, 16'h0000, 8'h00, 8'h00)) begin
        errors++;
        $display("FAIL info_byte%0d got %h want %h", i, got_byte(i), model_byte(c, i, 16'h0000, 8'h00, 8'h00));
      end
    end
  endtask

  task automatic test_status(input logic [15:0] b, input logic [7:0] x, input logic [7:0] y);
    buttons = b;
    stick_x = x;
    stick_y = y;
    clear_mon();
    send_frame(16'h0001, 8);
    wait_cv("status");
    repeat (40) @(negedge clk);
    buttons = ~b;
    stick_x = 8'($urandom);
    stick_y = ~y;
    wait_idle("status");
    checks++;
    if (cv_count !== 1 || cmd_byte !== 8'h01) begin
      errors++;
      $display("FAIL status_cmd got cv=%0d byte=%h want 1 01", cv_count, cmd_byte);
    end
    checks++;
    if (rx_bits.size() !== 32 || stop_seen !== 1) begin
      errors++;
      $display("FAIL status_len got bits=%0d stops=%0d want 32 1", rx_bits.size(), stop_seen);
    end
    for (int i = 0; i < model_len(8'h01); i++) begin
      checks++;
      if (got_byte(i) !== model_byte(8'h01, i, b, x, y)) begin
        errors++;
        $display("FAIL status_byte%0d got %h want %h", i, got_byte(i), model_byte(8'h01, i, b, x, y));
      end
    end
  endtask

  task automatic test_unknown(input logic [7:0] c);
    clear_mon();
    send_frame({8'h00, c}, 8);
    repeat (100 * US) @(negedge clk);
    checks++;
    if (cv_count !== 1 || cmd_byte !== c) begin
      errors++;
      $display("FAIL unknown_cmd got cv=%0d byte=%h want 1 %h", cv_count, cmd_byte, c);
    end
    checks++;
    if (oe_cycles !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL unknown_silent got oe_cycles=%0d busy=%b want 0 0", oe_cycles, busy);
    end
  endtask

  task automatic test_malformed();
    clear_mon();
    send_frame(16'h0200, 16);
    wait_idle("malformed");
    checks++;
    if (err_count !== 1 || cv_count !== 0 || oe_cycles !== 0) begin
      errors++;
      $display("FAIL malformed got err=%0d cv=%0d oe=%0d want 1 0 0", err_count, cv_count, oe_cycles);
    end
  endtask

  task automatic test_long_low();
    clear_mon();
    host_low = 1'b1;
    repeat (10 * US) @(negedge clk);
    host_low = 1'b0;
    repeat (5 * US) @(negedge clk);
    checks++;
    if (err_count !== 1 || cv_count !== 0) begin
      errors++;
      $display("FAIL long_low got err=%0d cv=%0d want 1 0", err_count, cv_count);
    end
    test_info(8'h00);
  endtask

  task automatic test_reset_mid_tx();
    int t = 0;
    clear_mon();
    buttons = 16'($urandom);
    send_frame(16'h0001, 8);
    while (!(rx_bits.size() >= 8 && joy_oe === 1'b1) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 3000) begin
      errors++;
      $display("FAIL reset_mid_tx_wait got bits=%0d want >=8 with oe=1", rx_bits.size());
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (joy_oe !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_release got oe=%b want 0", joy_oe);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cmd_byte !== 8'h00) begin
      errors++;
      $display("FAIL reset_recover got busy=%b byte=%h want 0 00", busy, cmd_byte);
    end
    test_info(8'h00);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_info(8'h00);
    test_info(8'hFF);
    test_status(16'h9030, 8'h7F, 8'h81);
    for (int i = 0; i < 3; i++) test_status(16'($urandom), 8'($urandom), 8'($urandom));
    test_unknown(8'h03);
    test_unknown(8'($urandom_range(2, 254)));
    test_malformed();
    test_long_low();
    test_reset_mid_tx();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
